// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM stage of the ARM pipeline with a fixed-latency word memory,
// upstream freeze generation and the MEM/WB pipeline register.
module data_mem_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int DEPTH = 64,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] st_val_in,
  input  logic [3:0]  dest_in,
  output logic        freeze,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic [31:0] wb_value
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] rbuf;
  logic [AW-1:0] idx;
  logic req, rd, wr, last, commit;
  assign req = mem_r_en_in | mem_w_en_in;
  assign wr = mem_w_en_in;
  assign rd = mem_r_en_in & ~mem_w_en_in;
  assign idx = AW'((alu_res_in - 32'(BASE_ADDR)) >> 2);
  assign wb_value = mem_r_en_out ? mem_data_out : alu_res_out;
  // The counter reaches zero on the commit edge, closing WAIT_CYCLES freeze cycles.
  assign last = cnt == CW'(1);
  always_comb begin
    nxt = IDLE;
    commit = 1'b0;
    freeze = 1'b0;
    if (state == IDLE) begin
      nxt = req ? (WAIT_CYCLES == 1 ? DONE : ACCESS) : IDLE;
      commit = req && WAIT_CYCLES == 1;
      freeze = req;
    end else if (state == ACCESS) begin
      nxt = last ? DONE : ACCESS;
      commit = last;
      freeze = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rbuf <= '0;
      wb_en_out <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out <= '0;
      mem_data_out <= '0;
      dest_out <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) cnt <= CW'(WAIT_CYCLES - 1);
      else if (state == ACCESS) cnt <= cnt - CW'(1);
      if (commit && rd) rbuf <= mem[idx];
      if ((state == IDLE && !req) || state == DONE) begin
        wb_en_out <= wb_en_in;
        mem_r_en_out <= rd;
        alu_res_out <= alu_res_in;
        mem_data_out <= (state == DONE && rd) ? rbuf : '0;
        dest_out <= dest_in;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && commit && wr) mem[idx] <= st_val_in;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of freeze timing, load/store data, wrap and reset abort.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst, wb_en_in, mem_r_en_in, mem_w_en_in, freeze, wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_in, st_val_in, alu_res_out, mem_data_out, wb_value;
  logic [3:0] dest_in, dest_out;
  int checks = 0;
  int failures = 0;
  data_mem_ctrl dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .st_val_in(st_val_in),
    .dest_in(dest_in), .freeze(freeze), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out), .wb_value(wb_value)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic w, input logic wb, input logic [31:0] a,
                       input logic [31:0] sv, input logic [3:0] d);
    mem_r_en_in = r;
    mem_w_en_in = w;
    wb_en_in = wb;
    alu_res_in = a;
    st_val_in = sv;
    dest_in = d;
  endtask
  task automatic mem_op(input string tag, input logic r, input logic w, input logic wb,
                        input logic [31:0] a, input logic [31:0] sv, input logic [3:0] d);
    drive(r, w, wb, a, sv, d);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_frz%0d", tag, i), 32'(freeze), 32'd1);
      tick();
    end
    check({tag, "_done_frz"}, 32'(freeze), 32'd0);
    tick();
  endtask
  task automatic outs(input string tag, input logic wb, input logic r, input logic [31:0] a,
                      input logic [31:0] md, input logic [3:0] d, input logic [31:0] wv);
    check({tag, "_wb_en"}, 32'(wb_en_out), 32'(wb));
    check({tag, "_r_en"}, 32'(mem_r_en_out), 32'(r));
    check({tag, "_alu"}, alu_res_out, a);
    check({tag, "_mdata"}, mem_data_out, md);
    check({tag, "_dest"}, 32'(dest_out), 32'(d));
    check({tag, "_wbval"}, wb_value, wv);
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("rst_frz", 32'(freeze), 32'd0);
    outs("rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 1, 32'h5, 0, 4'd3);
    #1;
    check("alu_frz", 32'(freeze), 32'd0);
    tick();
    outs("alu", 1, 0, 32'h5, 0, 4'd3, 32'h5);
    mem_op("st2", 0, 1, 0, 32'd1032, 32'hDEADBEEF, 4'd0);
    outs("st2", 0, 0, 32'd1032, 0, 4'd0, 32'd1032);
    mem_op("ld2", 1, 0, 1, 32'd1032, 0, 4'd7);
    outs("ld2", 1, 1, 32'd1032, 32'hDEADBEEF, 4'd7, 32'hDEADBEEF);
    mem_op("st0", 0, 1, 0, 32'd1280, 32'h11, 4'd1);
    outs("st0", 0, 0, 32'd1280, 0, 4'd1, 32'd1280);
    mem_op("b2b_a", 1, 0, 1, 32'd1024, 0, 4'd4);
    outs("b2b_a", 1, 1, 32'd1024, 32'h11, 4'd4, 32'h11);
    mem_op("b2b_b", 1, 0, 1, 32'd1035, 0, 4'd9);
    outs("b2b_b", 1, 1, 32'd1035, 32'hDEADBEEF, 4'd9, 32'hDEADBEEF);
    mem_op("rw", 1, 1, 1, 32'd1044, 32'h55, 4'd2);
    outs("rw", 1, 0, 32'd1044, 0, 4'd2, 32'd1044);
    mem_op("ld5", 1, 0, 1, 32'd1044, 0, 4'd6);
    outs("ld5", 1, 1, 32'd1044, 32'h55, 4'd6, 32'h55);
    drive(0, 1, 0, 32'd1044, 32'hCAFE, 4'd8);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("abort_frz%0d", i), 32'(freeze), 32'd1);
      tick();
    end
    check("abort_frz2", 32'(freeze), 32'd1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    outs("abort", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("abort_idle_frz", 32'(freeze), 32'd0);
    tick();
    mem_op("ld5b", 1, 0, 1, 32'd1044, 0, 4'd5);
    outs("ld5b", 1, 1, 32'd1044, 32'h55, 4'd5, 32'h55);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory stage of the 5-stage ARM pipeline; consumes the EXE/MEM register outputs (write-back enable, memory read/write enables, ALU result, store value, destination).
- Performs LDR/STR against an internal word-addressed data memory with a fixed multi-cycle access latency.
- Drives a freeze signal that stalls the upstream pipeline during an access.
- Contains the MEM/WB pipeline register that feeds the write-back path into the ID-stage register file.

Parameters:
- WAIT_CYCLES, 4, number of cycles freeze stays high per memory access; must be >= 1.
- DEPTH, 64, data memory size in 32-bit words; power of two.
- BASE_ADDR, 1024, byte address that maps to word 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_en_in  input  1  write-back enable from EXE/MEM register.
- mem_r_en_in  input  1  load request.
- mem_w_en_in  input  1  store request.
- alu_res_in  input  32  ALU result; byte address for loads and stores.
- st_val_in  input  32  store data.
- dest_in  input  4  destination register index.
- freeze  output  1  stall request to IF/ID/EXE and their registers; combinational from state and inputs.
- wb_en_out  output  1  registered write-back enable.
- mem_r_en_out  output  1  registered load flag (WB mux select).
- alu_res_out  output  32  registered ALU result.
- mem_data_out  output  32  registered load data.
- dest_out  output  4  registered destination.
- wb_value  output  32  equals mem_data_out when mem_r_en_out is 1, else alu_res_out; combinational.

Behaviour:
- Reset:
  - Next state is IDLE; wait counter is 0.
  - wb_en_out, mem_r_en_out, alu_res_out, mem_data_out and dest_out are all 0.
  - Memory contents are not cleared.
- Request definition: req = mem_r_en_in | mem_w_en_in. When both are set, the write wins and no read occurs; mem_r_en_out is then captured as 0.
- Address: idx = ((alu_res_in - BASE_ADDR) >> 2) modulo DEPTH.
  - Byte-offset bits [1:0] are ignored.
  - Out-of-range addresses wrap with no error.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - With req=0: freeze=0, and the MEM/WB register captures the inputs every cycle (mem_data_out is captured as 0).
  - With req=1: freeze=1 in this same cycle. Counter loads WAIT_CYCLES-1. Next state is ACCESS, or DONE directly if WAIT_CYCLES=1 (the memory operation then commits on this same edge).
- ACCESS:
  - freeze=1; counter decrements each cycle.
  - On the edge where the counter is 0, the operation commits: a write stores st_val_in into mem[idx]; a read latches mem[idx] into an internal read buffer. Next state is DONE.
- DONE:
  - freeze=0. The MEM/WB register captures the held instruction, with mem_data_out taken from the read buffer (0 for stores).
  - Next state is IDLE unconditionally. A request present in DONE is ignored, so an instruction is never accessed twice.
- Freeze timing: freeze is high for exactly WAIT_CYCLES consecutive cycles per access. Each memory instruction occupies WAIT_CYCLES+1 cycles in this stage.
- While freeze=1, the MEM/WB register holds its previous value. Repeating the previous write-back during the stall is harmless and permitted.
- Inputs are required to remain stable while freeze=1; upstream is held by freeze.
- Back-to-back memory instructions: the second request is seen in the IDLE cycle following DONE. Between the two accesses freeze is low for exactly one cycle (the DONE cycle).
- Reset mid-access: the FSM returns to IDLE and no memory write occurs, because a write commits only on the final ACCESS edge. If req is still asserted after reset, a fresh full access starts.

Test Plan:
- Non-memory op after reset: alu_res_in=0x5, dest_in=3, wb_en_in=1. Required: freeze never high; one edge later alu_res_out=0x5, dest_out=3, wb_en_out=1, wb_value=0x5.
- Store: mem_w_en_in=1, alu_res_in=1032, st_val_in=0xDEADBEEF, wb_en_in=0. Required: freeze high exactly 4 cycles, then low 1 cycle; mem[2]=0xDEADBEEF; wb_en_out=0 after DONE.
- Load from the same address: mem_r_en_in=1, wb_en_in=1, dest_in=7, alu_res_in=1032. Required: 4-cycle freeze; after DONE mem_data_out=0xDEADBEEF, mem_r_en_out=1, dest_out=7, wb_value=0xDEADBEEF.
- Back-to-back loads held across DONE: required freeze pattern 1111 0 1111 0; each load returns its own word.
- Wrap and misalignment:
  - Store 0x11 at alu_res_in=1024+256, then load alu_res_in=1024. Required: 0x11 (index wraps to 0).
  - Load alu_res_in=1035. Required: returns mem[2].
- Reset asserted in the third freeze cycle of a store of 0xCAFE to idx 5: required mem[5] unchanged, all outputs 0 after the reset edge. With the request dropped, freeze=0 on the next cycle.
